// File: rtl/vector_cmd_sequencer_if.sv
// Bus bundle between the vector command sequencer and its neighbours:
// UART RX/TX, the two vector banks and the compute unit.
// The master side is the sequencer; the slave side is the environment.
interface vector_cmd_sequencer_if #(
    parameter int ADDR_W    = 10,
    parameter int RES_BYTES = 4
);
    logic                   rx_ready;
    logic [7:0]             rx_data;
    logic                   wr_en_a;
    logic                   wr_en_b;
    logic [ADDR_W-1:0]      wr_addr;
    logic [7:0]             wr_data;
    logic [7:0]             op_code;
    logic                   op_start;
    logic                   op_done;
    logic [RES_BYTES*8-1:0] result;
    logic                   tx_start;
    logic [7:0]             tx_data;
    logic                   tx_busy;
    logic                   busy;
    logic                   rx_drop;

    modport master (
        input  rx_ready, rx_data, op_done, result, tx_busy,
        output wr_en_a, wr_en_b, wr_addr, wr_data, op_code, op_start,
               tx_start, tx_data, busy, rx_drop
    );

    modport slave (
        output rx_ready, rx_data, op_done, result, tx_busy,
        input  wr_en_a, wr_en_b, wr_addr, wr_data, op_code, op_start,
               tx_start, tx_data, busy, rx_drop
    );
endinterface

// File: rtl/vector_cmd_sequencer.sv
// UART command sequencer for the vector coprocessor.
// Header 0x00 starts a vector load (bank select byte, then VEC_LEN data
// bytes); any other header is a command that launches the compute unit and
// returns its result over UART TX, most significant byte first.
// Every output is a register; the comb block computes all next values.
module vector_cmd_sequencer #(
    parameter int VEC_LEN   = 1024,
    parameter int ADDR_W    = 10,
    parameter int RES_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    vector_cmd_sequencer_if.master bus
);

    localparam int IDX_W = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VEC_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(RES_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_BANK,
        LOAD,
        EXEC,
        WAIT_DONE,
        TX_SEND,
        TX_WAIT
    } state_t;

    state_t                 r_state,   w_state;
    logic [ADDR_W-1:0]      r_cnt,     w_cnt;
    logic                   r_bankSel, w_bankSel;
    logic [RES_BYTES*8-1:0] r_shift,   w_shift;
    logic [IDX_W-1:0]       r_idx,     w_idx;
    logic                   r_txFirst, w_txFirst;
    logic                   r_wrEnA,   w_wrEnA;
    logic                   r_wrEnB,   w_wrEnB;
    logic [ADDR_W-1:0]      r_wrAddr,  w_wrAddr;
    logic [7:0]             r_wrData,  w_wrData;
    logic [7:0]             r_opCode,  w_opCode;
    logic                   r_opStart, w_opStart;
    logic                   r_txStart, w_txStart;
    logic [7:0]             r_txData,  w_txData;
    logic                   r_busy,    w_busy;
    logic                   r_rxDrop,  w_rxDrop;

    // Next-state and next-output logic; pulses default low, everything else holds
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_bankSel = r_bankSel;
        w_shift   = r_shift;
        w_idx     = r_idx;
        w_txFirst = r_txFirst;
        w_wrEnA   = 1'b0;
        w_wrEnB   = 1'b0;
        w_wrAddr  = r_wrAddr;
        w_wrData  = r_wrData;
        w_opCode  = r_opCode;
        w_opStart = 1'b0;
        w_txStart = 1'b0;
        w_txData  = r_txData;
        w_rxDrop  = r_rxDrop;

        case (r_state)
            IDLE: begin
                if (bus.rx_ready) begin
                    if (bus.rx_data == 8'h00) begin
                        w_state = GET_BANK;
                    end else begin
                        w_opCode = bus.rx_data;
                        w_state  = EXEC;
                    end
                end
            end
            GET_BANK: begin
                if (bus.rx_ready) begin
                    w_bankSel = (bus.rx_data != 8'h00);
                    w_cnt     = '0;
                    w_state   = LOAD;
                end
            end
            LOAD: begin
                if (bus.rx_ready) begin
                    w_wrEnA  = ~r_bankSel;
                    w_wrEnB  = r_bankSel;
                    w_wrAddr = r_cnt;
                    w_wrData = bus.rx_data;
                    if (r_cnt == LAST_ADDR) begin
                        w_state = IDLE;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            EXEC: begin
                w_opStart = 1'b1;
                w_state   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.op_done) begin
                    w_shift = bus.result;
                    w_idx   = '0;
                    w_state = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!bus.tx_busy) begin
                    w_txStart = 1'b1;
                    w_txData  = r_shift[RES_BYTES*8-1 -: 8];
                    w_shift   = r_shift << 8;
                    w_txFirst = 1'b1;
                    w_state   = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (r_txFirst) begin
                    w_txFirst = 1'b0;
                end else if (!bus.tx_busy) begin
                    if (r_idx == LAST_IDX) begin
                        w_state = IDLE;
                    end else begin
                        w_idx   = r_idx + 1'b1;
                        w_state = TX_SEND;
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        if (bus.rx_ready && (r_state == EXEC || r_state == WAIT_DONE ||
                             r_state == TX_SEND || r_state == TX_WAIT)) begin
            w_rxDrop = 1'b1;
        end

        w_busy = (w_state != IDLE);
    end

    // State and output registers, cleared together by the synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bankSel <= 1'b0;
            r_shift   <= '0;
            r_idx     <= '0;
            r_txFirst <= 1'b0;
            r_wrEnA   <= 1'b0;
            r_wrEnB   <= 1'b0;
            r_wrAddr  <= '0;
            r_wrData  <= '0;
            r_opCode  <= '0;
            r_opStart <= 1'b0;
            r_txStart <= 1'b0;
            r_txData  <= '0;
            r_busy    <= 1'b0;
            r_rxDrop  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_bankSel <= w_bankSel;
            r_shift   <= w_shift;
            r_idx     <= w_idx;
            r_txFirst <= w_txFirst;
            r_wrEnA   <= w_wrEnA;
            r_wrEnB   <= w_wrEnB;
            r_wrAddr  <= w_wrAddr;
            r_wrData  <= w_wrData;
            r_opCode  <= w_opCode;
            r_opStart <= w_opStart;
            r_txStart <= w_txStart;
            r_txData  <= w_txData;
            r_busy    <= w_busy;
            r_rxDrop  <= w_rxDrop;
        end
    end

    assign bus.wr_en_a  = r_wrEnA;
    assign bus.wr_en_b  = r_wrEnB;
    assign bus.wr_addr  = r_wrAddr;
    assign bus.wr_data  = r_wrData;
    assign bus.op_code  = r_opCode;
    assign bus.op_start = r_opStart;
    assign bus.tx_start = r_txStart;
    assign bus.tx_data  = r_txData;
    assign bus.busy     = r_busy;
    assign bus.rx_drop  = r_rxDrop;

endmodule

// File: tb/tb_vector_cmd_sequencer.sv
// Directed bench for vector_cmd_sequencer with an 8-byte vector length.
// A negedge monitor logs bank writes, op_start pulses and transmitted bytes;
// a small UART TX model raises tx_busy the cycle after each tx_start.
module tb_vector_cmd_sequencer;

    localparam int VEC_LEN   = 8;
    localparam int ADDR_W    = 10;
    localparam int RES_BYTES = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic modelBusy = 1'b0;
    logic forceBusy = 1'b0;

    int checks = 0;
    int failures = 0;

    bit          wrBank[$];
    logic [9:0]  wrAddr[$];
    logic [7:0]  wrData[$];
    logic [7:0]  txLog[$];
    int          opStartCount = 0;
    int          bothHigh = 0;

    vector_cmd_sequencer_if #(.ADDR_W(ADDR_W), .RES_BYTES(RES_BYTES)) bus();

    vector_cmd_sequencer #(
        .VEC_LEN  (VEC_LEN),
        .ADDR_W   (ADDR_W),
        .RES_BYTES(RES_BYTES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    assign bus.tx_busy = modelBusy | forceBusy;

    // Free-running clock
    always #5 clk = ~clk;

    // Record every DUT-side event away from the active edge
    always @(negedge clk) begin
        if (bus.wr_en_a && bus.wr_en_b) bothHigh++;
        if (bus.wr_en_a || bus.wr_en_b) begin
            wrBank.push_back(bus.wr_en_b);
            wrAddr.push_back(bus.wr_addr);
            wrData.push_back(bus.wr_data);
        end
        if (bus.op_start) opStartCount++;
        if (bus.tx_start) txLog.push_back(bus.tx_data);
    end

    // UART TX model: busy from the cycle after tx_start for a few cycles
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_start) begin
                @(posedge clk);
                #1 modelBusy = 1'b1;
                repeat (3) @(posedge clk);
                #1 modelBusy = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic pulseDone(input logic [31:0] res);
        @(posedge clk);
        #1;
        bus.op_done = 1'b1;
        bus.result  = res;
        @(posedge clk);
        #1;
        bus.op_done = 1'b0;
        bus.result  = 32'h0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait for n logged tx bytes, then for the sequencer to go idle
    task automatic waitTxDone(input string tag, input int n);
        int cyc;
        cyc = 0;
        while ((txLog.size() < n || bus.busy) && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({tag, "_txcount"}, txLog.size(), n);
        checkOutput({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    task automatic checkTx(input string tag, input int base, input logic [31:0] res);
        logic [31:0] r;
        r = res;
        for (int i = 0; i < 4; i++) begin
            if (base + i < txLog.size())
                checkOutput({tag, "_byte"}, txLog[base + i], r[31 - 8*i -: 8]);
            else
                checkOutput({tag, "_missing"}, 32'hFFFF_FFFF, r[31 - 8*i -: 8]);
        end
    endtask

    initial begin
        int base;
        int txBase;
        int opBase;

        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.op_done  = 1'b0;
        bus.result   = 32'h0;

        // Reset state
        waitCycles(3);
        reset = 1'b0;
        checkOutput("rst_busy", bus.busy, 1'b0);
        checkOutput("rst_wr_en_a", bus.wr_en_a, 1'b0);
        checkOutput("rst_wr_en_b", bus.wr_en_b, 1'b0);
        checkOutput("rst_op_start", bus.op_start, 1'b0);
        checkOutput("rst_tx_start", bus.tx_start, 1'b0);
        checkOutput("rst_rx_drop", bus.rx_drop, 1'b0);
        checkOutput("rst_op_code", bus.op_code, 8'h00);

        // Load into bank A: 00, 00, 10..17
        $display("[TB] bank A load");
        base = wrAddr.size();
        applyStimulus(8'h00);
        checkOutput("loadA_busy_hdr", bus.busy, 1'b1);
        applyStimulus(8'h00);
        applyStimulus(8'h10);
        checkOutput("loadA_first_wr_en_a", bus.wr_en_a, 1'b1);
        checkOutput("loadA_first_addr", bus.wr_addr, 10'd0);
        checkOutput("loadA_first_data", bus.wr_data, 8'h10);
        for (int i = 1; i < 8; i++) applyStimulus(8'h10 + 8'(i));
        checkOutput("loadA_busy_after", bus.busy, 1'b0);
        waitCycles(2);
        checkOutput("loadA_count", wrAddr.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < wrAddr.size()) begin
                checkOutput("loadA_bank", wrBank[base + i], 1'b0);
                checkOutput("loadA_addr", wrAddr[base + i], i);
                checkOutput("loadA_data", wrData[base + i], 8'h10 + 8'(i));
            end
        end

        // Load into bank B with a nonzero select byte
        $display("[TB] bank B load");
        base = wrAddr.size();
        applyStimulus(8'h00);
        applyStimulus(8'h05);
        for (int i = 0; i < 8; i++) applyStimulus(8'h20 + 8'(i));
        waitCycles(2);
        checkOutput("loadB_count", wrAddr.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < wrAddr.size()) begin
                checkOutput("loadB_bank", wrBank[base + i], 1'b1);
                checkOutput("loadB_addr", wrAddr[base + i], i);
                checkOutput("loadB_data", wrData[base + i], 8'h20 + 8'(i));
            end
        end
        checkOutput("loadB_busy_after", bus.busy, 1'b0);

        // Command 03 with result DEADBEEF
        $display("[TB] command 03");
        txBase = txLog.size();
        opBase = opStartCount;
        applyStimulus(8'h03);
        checkOutput("cmd_op_code", bus.op_code, 8'h03);
        checkOutput("cmd_op_start_early", bus.op_start, 1'b0);
        waitCycles(1);
        checkOutput("cmd_op_start", bus.op_start, 1'b1);
        waitCycles(1);
        checkOutput("cmd_op_start_width", bus.op_start, 1'b0);
        waitCycles(3);
        pulseDone(32'hDEADBEEF);
        waitTxDone("cmd03", txBase + 4);
        checkTx("cmd03", txBase, 32'hDEADBEEF);
        checkOutput("cmd03_op_starts", opStartCount - opBase, 1);

        // Stray op_done while idle must not start a transmission
        txBase = txLog.size();
        pulseDone(32'h12345678);
        waitCycles(10);
        checkOutput("stray_done_tx", txLog.size() - txBase, 0);
        checkOutput("stray_done_busy", bus.busy, 1'b0);

        // tx_busy held high for 20 cycles while a byte is pending
        $display("[TB] tx_busy hold");
        txBase = txLog.size();
        applyStimulus(8'h07);
        waitCycles(3);
        forceBusy = 1'b1;
        pulseDone(32'h11223344);
        waitCycles(20);
        checkOutput("hold_no_tx", txLog.size() - txBase, 0);
        forceBusy = 1'b0;
        waitTxDone("hold", txBase + 4);
        checkTx("hold", txBase, 32'h11223344);
        checkOutput("hold_rx_drop", bus.rx_drop, 1'b0);

        // rx byte during WAIT_DONE is dropped
        $display("[TB] drop during WAIT_DONE");
        txBase = txLog.size();
        opBase = opStartCount;
        base = wrAddr.size();
        applyStimulus(8'h09);
        waitCycles(3);
        applyStimulus(8'h00);
        checkOutput("drop_rx_drop", bus.rx_drop, 1'b1);
        waitCycles(3);
        pulseDone(32'hCAFEF00D);
        waitTxDone("drop", txBase + 4);
        checkTx("drop", txBase, 32'hCAFEF00D);
        checkOutput("drop_no_write", wrAddr.size() - base, 0);
        checkOutput("drop_op_starts", opStartCount - opBase, 1);
        checkOutput("drop_op_code", bus.op_code, 8'h09);
        checkOutput("drop_sticky", bus.rx_drop, 1'b1);

        // Reset in the middle of a load, then a fresh load from address 0
        $display("[TB] reset mid-load");
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'hA0);
        applyStimulus(8'hA1);
        applyStimulus(8'hA2);
        checkOutput("mid_wr_addr", bus.wr_addr, 10'd2);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("mid_rst_busy", bus.busy, 1'b0);
        checkOutput("mid_rst_rx_drop", bus.rx_drop, 1'b0);
        checkOutput("mid_rst_wr_addr", bus.wr_addr, 10'd0);
        checkOutput("mid_rst_wr_data", bus.wr_data, 8'h00);
        checkOutput("mid_rst_op_code", bus.op_code, 8'h00);
        checkOutput("mid_rst_tx_data", bus.tx_data, 8'h00);
        base = wrAddr.size();
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        for (int i = 0; i < 8; i++) applyStimulus(8'hB0 + 8'(i));
        waitCycles(2);
        checkOutput("reload_count", wrAddr.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < wrAddr.size()) begin
                checkOutput("reload_bank", wrBank[base + i], 1'b0);
                checkOutput("reload_addr", wrAddr[base + i], i);
                checkOutput("reload_data", wrData[base + i], 8'hB0 + 8'(i));
            end
        end
        checkOutput("reload_busy", bus.busy, 1'b0);
        checkOutput("never_both_banks", bothHigh, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the directed sequence stalls
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
